// File: rtl/mem_port_arbiter.sv
// Shares one single-request memory port between instruction fetch (I) and load/store (D).
// D has fixed priority; a starvation counter forces an I grant after STARVE_LIMIT lost cycles.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);

  // Handshake: a requester holds req (and its address/data) until it sees ack
  // in the same cycle; the read return follows with rvalid exactly one cycle later.

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_DL   = 2'd2
  } owner_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [2:0]       F3_LW = 3'b010;

  owner_t           owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             grant_i;
  logic             grant_d;

  always_comb begin
    starved = (starve_cnt == LIMIT);
    grant_i = rst_n && i_req && (starved || !d_req);
    grant_d = rst_n && d_req && !grant_i;
  end

  assign i_ack = grant_i;
  assign d_ack = grant_d;

  always_comb begin
    mem_write         = 1'b0;
    mem_funct3        = F3_LW;
    mem_write_address = 32'd0;
    mem_write_data    = 32'd0;
    mem_read_address  = 32'd0;
    if (grant_i) begin
      mem_read_address = i_addr;
    end else if (grant_d) begin
      mem_funct3       = d_funct3;
      mem_read_address = d_addr;
      if (d_we) begin
        mem_write         = 1'b1;
        mem_write_address = d_addr;
        mem_write_data    = d_wdata;
      end
    end
  end

  // Owner of the read in flight; stores and idle cycles leave nothing to return.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      if (grant_i) begin
        owner <= OWN_I;
      end else if (grant_d && !d_we) begin
        owner <= OWN_DL;
      end else begin
        owner <= OWN_NONE;
      end

      if (!i_req || grant_i) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign i_rvalid = (owner == OWN_I);
  assign d_rvalid = (owner == OWN_DL);
  assign i_rdata  = mem_read_data;
  assign d_rdata  = mem_read_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RV32I-width memory and a
// scoreboard queue of expected read returns checked by an independent monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        i_ack;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_funct3 = 3'd0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_ack;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_data = 32'd0;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Behavioural memory: data registered with its funct3, returned already extended.
  logic [31:0] mem [0:255];
  bit          mem_init = 1'b0;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] m;
    logic [31:0] d;
    case (f3)
      3'b000:  begin m = 32'h0000_00FF << {off, 3'b000}; d = (wd & 32'hFF) << {off, 3'b000}; end
      3'b001:  begin m = 32'h0000_FFFF << {off, 3'b000}; d = (wd & 32'hFFFF) << {off, 3'b000}; end
      default: begin m = 32'hFFFF_FFFF; d = wd; end
    endcase
    return (w & ~m) | (d & m);
  endfunction

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      mem[4] = 32'hDEAD_BEEF;
      mem_init = 1'b1;
    end
    mem_read_data <= load_ext(mem[mem_read_address[9:2]], mem_read_address[1:0], mem_funct3);
    if (mem_write)
      mem[mem_write_address[9:2]] = store_merge(mem[mem_write_address[9:2]],
                                                mem_write_address[1:0], mem_funct3, mem_write_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: inputs applied just after the edge, combinational outputs checked mid-cycle.
  task automatic drive(input logic rst, input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwe, input logic [2:0] df3,
                       input logic [31:0] daddr, input logic [31:0] dwdata,
                       input logic exp_i, input logic exp_d, input logic push,
                       input logic [31:0] exp_rdata);
    @(posedge clk);
    #1;
    rst_n = rst; i_req = ireq; i_addr = iaddr; d_req = dreq; d_we = dwe;
    d_funct3 = df3; d_addr = daddr; d_wdata = dwdata;
    @(negedge clk);
    chk("i_ack", {31'd0, i_ack}, {31'd0, exp_i});
    chk("d_ack", {31'd0, d_ack}, {31'd0, exp_d});
    chk("mem_write", {31'd0, mem_write}, {31'd0, exp_d && dwe});
    chk("mem_funct3", {29'd0, mem_funct3}, {29'd0, exp_d ? df3 : 3'b010});
    chk("mem_read_address", mem_read_address, exp_i ? iaddr : (exp_d ? daddr : 32'd0));
    chk("mem_write_address", mem_write_address, (exp_d && dwe) ? daddr : 32'd0);
    chk("mem_write_data", mem_write_data, (exp_d && dwe) ? dwdata : 32'd0);
    if (push && (exp_i || (exp_d && !dwe))) exp_q.push_back({exp_d, exp_rdata});
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Monitor: each queued return is due in the cycle right after its issue.
  initial begin
    logic [32:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (i_rvalid && d_rvalid) chk("rvalid_both", 32'd1, 32'd0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rvalid_present", {31'd0, i_rvalid | d_rvalid}, 32'd1);
        chk("rvalid_owner_d", {31'd0, d_rvalid}, {31'd0, e[32]});
        chk("rvalid_owner_i", {31'd0, i_rvalid}, {31'd0, !e[32]});
        chk("rdata", e[32] ? d_rdata : i_rdata, e[31:0]);
      end else if (i_rvalid || d_rvalid) begin
        chk("rvalid_unexpected", {31'd0, i_rvalid | d_rvalid}, 32'd0);
      end
    end
  end

  initial begin
    // Reset held with both requesters active: no acks, no returns.
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
      chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    end
    // Release: D first, counter climbs from 0, I forced on the 5th cycle.
    for (int k = 0; k < 5; k++)
      drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0,
            k == 4, k != 4, 1'b1, 32'hDEAD_BEEF);
    idle();

    // I alone, three back-to-back fetches.
    for (int k = 0; k < 3; k++)
      drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    idle();

    // Byte store then unsigned byte load of the same address.
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 3'b000, 32'h100, 32'h0000_00AB, 1'b0, 1'b1, 1'b1, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 3'b100, 32'h100, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_00AB);
    idle();

    // Both held: D,D,D,D,I repeating.
    for (int k = 0; k < 10; k++)
      drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 3'b010, 32'h100, 32'd0,
            (k % 5) == 4, (k % 5) != 4, 1'b1, ((k % 5) == 4) ? 32'hDEAD_BEEF : 32'h0000_00AB);
    idle();

    // Alternating owners with sign/zero-extended loads and idle gaps.
    drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 3'b000, 32'h13, 32'd0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFDE);
    idle();
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 3'b101, 32'h10, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_BEEF);
    drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    idle();

    // Reset right after a D load ack: return dropped, counter restarts from 0.
    drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_00AB);
    drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("midrst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    for (int k = 0; k < 5; k++)
      drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 3'b010, 32'h100, 32'd0,
            k == 4, k != 4, 1'b1, (k == 4) ? 32'hDEAD_BEEF : 32'h0000_00AB);
    idle();
    idle();

    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
